// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates cache instruction-fill (I) and data-access (D) miss traffic onto
//   one single-ported, fixed-latency backing memory. Unprivileged D writes below
//   RESERVED_AREA are rejected with d_err and never reach memory.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   i_req/i_addr        instruction read request (held until i_ack)
//   i_ack/i_rdata       one-cycle completion pulse with read data
//   d_req/d_we/d_priv   data request, write enable, privileged access
//   d_addr/d_wdata      data address and write data
//   d_ack/d_rdata/d_err one-cycle completion pulse, read data, blocked-write flag
//   mem_re/mem_we       one-cycle memory command strobes (never both)
//   mem_addr/mem_wdata  memory address / write data, valid with the strobe
//   mem_rdata           memory read data, valid MEM_LAT cycles after mem_re
//   busy                high whenever the arbiter is not idle
module mem_arbiter #(
  parameter logic [15:0] RESERVED_AREA = 16'h1000,
  parameter int unsigned MEM_LAT       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ack,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_priv,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        d_err,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cbit_q, cbit_d;      // I side lost the last contended arbitration
  logic        side_i_q, side_i_d;  // 1 = I side granted
  logic        we_q, we_d;

  logic        i_ack_q, i_ack_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic        d_ack_q, d_ack_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;

  logic        grant_i;
  logic        blocked;
  logic        gnt_we;
  logic [15:0] gnt_addr;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cbit_d      = cbit_q;
    side_i_d    = side_i_q;
    we_d        = we_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    grant_i     = i_req && (!d_req || cbit_q);
    gnt_we      = !grant_i && d_we;
    gnt_addr    = grant_i ? i_addr : d_addr;
    blocked     = !grant_i && d_we && !d_priv && (d_addr < RESERVED_AREA);

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          side_i_d = grant_i;
          we_d     = gnt_we;
          if (grant_i)    cbit_d = 1'b0;
          else if (i_req) cbit_d = 1'b1;
          if (blocked) begin
            // Rejected write skips the memory entirely and completes next cycle.
            state_d = DONE;
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
          end else begin
            // Command outputs are registered, so they are loaded on the grant
            // edge and appear exactly during the ISSUE cycle.
            state_d     = ISSUE;
            mem_re_d    = !gnt_we;
            mem_we_d    = gnt_we;
            mem_addr_d  = gnt_addr;
            mem_wdata_d = gnt_we ? d_wdata : '0;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = LAT_LOAD;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          if (side_i_q) begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!we_q) d_rdata_d = mem_rdata;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cbit_q      <= 1'b0;
      side_i_q    <= 1'b0;
      we_q        <= 1'b0;
      i_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cbit_q      <= cbit_d;
      side_i_q    <= side_i_d;
      we_q        <= we_d;
      i_ack_q     <= i_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance with MEM_LAT=3
  logic        i_req_3 = 0, d_req_3 = 0, d_we_3 = 0, d_priv_3 = 0;
  logic [15:0] i_addr_3 = 0, d_addr_3 = 0, d_wdata_3 = 0, mem_rdata_3 = 16'hDEAD;
  logic        i_ack_3, d_ack_3, d_err_3, mem_re_3, mem_we_3, busy_3;
  logic [15:0] i_rdata_3, d_rdata_3, mem_addr_3, mem_wdata_3;

  // Instance with MEM_LAT=1
  logic        i_req_1 = 0, d_req_1 = 0, d_we_1 = 0, d_priv_1 = 0;
  logic [15:0] i_addr_1 = 0, d_addr_1 = 0, d_wdata_1 = 0, mem_rdata_1 = 16'hDEAD;
  logic        i_ack_1, d_ack_1, d_err_1, mem_re_1, mem_we_1, busy_1;
  logic [15:0] i_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1;

  mem_arbiter #(.RESERVED_AREA(16'h1000), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .i_req(i_req_3), .i_addr(i_addr_3), .i_ack(i_ack_3), .i_rdata(i_rdata_3),
    .d_req(d_req_3), .d_we(d_we_3), .d_priv(d_priv_3), .d_addr(d_addr_3),
    .d_wdata(d_wdata_3), .d_ack(d_ack_3), .d_rdata(d_rdata_3), .d_err(d_err_3),
    .mem_re(mem_re_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3),
    .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3), .busy(busy_3)
  );

  mem_arbiter #(.RESERVED_AREA(16'h1000), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req_1), .i_addr(i_addr_1), .i_ack(i_ack_1), .i_rdata(i_rdata_1),
    .d_req(d_req_1), .d_we(d_we_1), .d_priv(d_priv_1), .d_addr(d_addr_1),
    .d_wdata(d_wdata_1), .d_ack(d_ack_1), .d_rdata(d_rdata_1), .d_err(d_err_1),
    .mem_re(mem_re_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
    .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1), .busy(busy_1)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return (a == 16'h0042) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // Memory models: data is presented only in the single cycle the arbiter
  // must sample it (MEM_LAT cycles after the mem_re cycle).
  int          cnt3 = 0, cnt1 = 0;
  logic [15:0] raddr3 = 0, raddr1 = 0;
  int          nwr3 = 0, both_hi = 0;
  logic [15:0] last_waddr3 = 0, last_wdata3 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      cnt3 = 0; mem_rdata_3 = 16'hDEAD;
      cnt1 = 0; mem_rdata_1 = 16'hDEAD;
    end else begin
      if (cnt3 == 1) begin cnt3 = 0; mem_rdata_3 = mem_val(raddr3); end
      else begin mem_rdata_3 = 16'hDEAD; if (cnt3 > 0) cnt3--; end
      if (mem_re_3) begin cnt3 = 3; raddr3 = mem_addr_3; end
      if (cnt1 == 1) begin cnt1 = 0; mem_rdata_1 = mem_val(raddr1); end
      else begin mem_rdata_1 = 16'hDEAD; if (cnt1 > 0) cnt1--; end
      if (mem_re_1) begin cnt1 = 1; raddr1 = mem_addr_1; end
    end
    if (mem_we_3) begin nwr3++; last_waddr3 = mem_addr_3; last_wdata3 = mem_wdata_3; end
    if ((mem_re_3 && mem_we_3) || (mem_re_1 && mem_we_1)) both_hi++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps cycle by cycle until an ack on the selected instance (bounded).
  task automatic await_ack(input bit sel1, output int lat, output int re_at,
                           output int we_at, output int busy_lo,
                           output logic [15:0] waddr, output bit acked_i,
                           output bit err);
    lat = 0; re_at = 0; we_at = 0; busy_lo = 0; waddr = '0; acked_i = 0; err = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (sel1 ? mem_re_1 : mem_re_3) re_at = i;
      if (sel1 ? mem_we_1 : mem_we_3) begin
        we_at = i; waddr = sel1 ? mem_addr_1 : mem_addr_3;
      end
      if (!(sel1 ? busy_1 : busy_3)) busy_lo++;
      if (sel1 ? (i_ack_1 || d_ack_1) : (i_ack_3 || d_ack_3)) begin
        lat = i;
        acked_i = sel1 ? i_ack_1 : i_ack_3;
        err = sel1 ? d_err_1 : d_err_3;
        break;
      end
    end
  endtask

  int lat, re_at, we_at, busy_lo, seen;
  logic [15:0] waddr;
  bit acked_i, err;

  initial begin
    // Reset state
    #2;
    check("rst_outs3", {i_ack_3, d_ack_3, d_err_3, mem_re_3, mem_we_3, busy_3}, 0);
    check("rst_data3", {i_rdata_3, d_rdata_3}, 0);
    check("rst_mem3", {mem_addr_3, mem_wdata_3}, 0);
    check("rst_outs1", {i_ack_1, d_ack_1, d_err_1, mem_re_1, mem_we_1, busy_1}, 0);
    step(); step();
    rst = 1;
    step();

    // Lone I read
    i_req_3 = 1; i_addr_3 = 16'h0042;
    check("t1_busy_T", busy_3, 0);
    await_ack(0, lat, re_at, we_at, busy_lo, waddr, acked_i, err);
    check("t1_lat", lat, 5);
    check("t1_re_at", re_at, 1);
    check("t1_we_at", we_at, 0);
    check("t1_busy_lo", busy_lo, 0);
    check("t1_side_i", acked_i, 1);
    check("t1_rdata", i_rdata_3, 16'hBEEF);
    check("t1_no_dack", d_ack_3, 0);
    i_req_3 = 0;
    step();
    check("t1_idle_busy", busy_3, 0);
    check("t1_ack_pulse", i_ack_3, 0);

    // Contention: both held, alternating grants starting with D
    i_req_3 = 1; i_addr_3 = 16'h0042;
    d_req_3 = 1; d_we_3 = 0; d_priv_3 = 0; d_addr_3 = 16'h2000;
    await_ack(0, lat, re_at, we_at, busy_lo, waddr, acked_i, err);
    check("t2_lat0", lat, 5);
    check("t2_side0", acked_i, 0);
    check("t2_drdata", d_rdata_3, 16'h7A5A);
    await_ack(0, lat, re_at, we_at, busy_lo, waddr, acked_i, err);
    check("t2_lat1", lat, 6);
    check("t2_side1", acked_i, 1);
    check("t2_irdata", i_rdata_3, 16'hBEEF);
    await_ack(0, lat, re_at, we_at, busy_lo, waddr, acked_i, err);
    check("t2_lat2", lat, 6);
    check("t2_side2", acked_i, 0);
    await_ack(0, lat, re_at, we_at, busy_lo, waddr, acked_i, err);
    check("t2_lat3", lat, 6);
    check("t2_side3", acked_i, 1);
    i_req_3 = 0; d_req_3 = 0;
    step();

    // Blocked unprivileged write into reserved area
    d_req_3 = 1; d_we_3 = 1; d_priv_3 = 0; d_addr_3 = 16'h0800; d_wdata_3 = 16'h1234;
    await_ack(0, lat, re_at, we_at, busy_lo, waddr, acked_i, err);
    check("t3_lat", lat, 1);
    check("t3_err", err, 1);
    check("t3_we_at", we_at, 0);
    check("t3_re_at", re_at, 0);
    check("t3_drdata_hold", d_rdata_3, 16'h7A5A);
    d_req_3 = 0;
    step();
    check("t3_err_pulse", d_err_3, 0);
    check("t3_nwr", nwr3, 0);

    // Same write, privileged
    d_req_3 = 1; d_priv_3 = 1;
    await_ack(0, lat, re_at, we_at, busy_lo, waddr, acked_i, err);
    check("t4_lat", lat, 5);
    check("t4_we_at", we_at, 1);
    check("t4_waddr", waddr, 16'h0800);
    check("t4_err", err, 0);
    check("t4_wdata", last_wdata3, 16'h1234);
    check("t4_drdata_hold", d_rdata_3, 16'h7A5A);
    d_req_3 = 0;
    step();

    // Write exactly at the reserved boundary, unprivileged
    d_req_3 = 1; d_priv_3 = 0; d_addr_3 = 16'h1000; d_wdata_3 = 16'h5678;
    await_ack(0, lat, re_at, we_at, busy_lo, waddr, acked_i, err);
    check("t5_lat", lat, 5);
    check("t5_we_at", we_at, 1);
    check("t5_err", err, 0);
    check("t5_waddr", last_waddr3, 16'h1000);
    check("t5_nwr", nwr3, 2);
    d_req_3 = 0; d_we_3 = 0;
    step();

    // MEM_LAT=1 back-to-back I reads
    i_req_1 = 1; i_addr_1 = 16'h0010;
    await_ack(1, lat, re_at, we_at, busy_lo, waddr, acked_i, err);
    check("t6_lat0", lat, 3);
    check("t6_re_at", re_at, 1);
    check("t6_rdata0", i_rdata_1, 16'h5A4A);
    i_addr_1 = 16'h0011;
    await_ack(1, lat, re_at, we_at, busy_lo, waddr, acked_i, err);
    check("t6_lat1", lat, 4);
    check("t6_rdata1", i_rdata_1, 16'h5A4B);
    i_addr_1 = 16'h0012;
    await_ack(1, lat, re_at, we_at, busy_lo, waddr, acked_i, err);
    check("t6_lat2", lat, 4);
    check("t6_rdata2", i_rdata_1, 16'h5A48);
    i_req_1 = 0;
    step();

    // Reset during WAIT
    d_req_3 = 1; d_we_3 = 0; d_addr_3 = 16'h3000;
    step(); step(); step();
    check("t7_busy_wait", busy_3, 1);
    #2 rst = 0;
    #1;
    check("t7_async_outs", {i_ack_3, d_ack_3, d_err_3, mem_re_3, mem_we_3, busy_3}, 0);
    check("t7_async_data", {i_rdata_3, d_rdata_3}, 0);
    d_req_3 = 0;
    step(); step();
    rst = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (d_ack_3 || i_ack_3 || busy_3) seen++;
    end
    check("t7_no_ack", seen, 0);
    d_req_3 = 1;
    await_ack(0, lat, re_at, we_at, busy_lo, waddr, acked_i, err);
    check("t7_lat", lat, 5);
    check("t7_drdata", d_rdata_3, 16'h6A5A);
    check("t7_err", err, 0);
    d_req_3 = 0;
    step();

    check("never_both_strobes", both_hi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
